// File: rtl/jtag_debug_pkg.sv
// Shared types and constants for the sysclk-side JTAG debug command decoder.
// Holds the FSM state encoding, default widths and the named IR command codes.
package jtag_debug_pkg;

  localparam int DEF_IR_W    = 2;
  localparam int DEF_DR_W    = 38;
  localparam int DEF_ACT_BIT = 35;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ISSUE   = 2'd2,
    HOLD    = 2'd3
  } cmd_state_e;

  localparam logic [DEF_IR_W-1:0] OCIMEM    = 2'd0;
  localparam logic [DEF_IR_W-1:0] TRACEMEM  = 2'd1;
  localparam logic [DEF_IR_W-1:0] BREAK     = 2'd2;
  localparam logic [DEF_IR_W-1:0] TRACECTRL = 2'd3;

endpackage

// File: rtl/jtag_debug_cmd_sync_if.sv
// Bus between the TCK-side shift logic and the sysclk command decoder.
// master drives the update strobes and scan data; slave is the decoder.
interface jtag_debug_cmd_sync_if
  import jtag_debug_pkg::*;
#(
  parameter int IR_W  = DEF_IR_W,
  parameter int DR_W  = DEF_DR_W,
  parameter int CNT_W = 16
);
  localparam int NUM_CMDS = 2 ** IR_W;

  logic                uir_in;
  logic                udr_in;
  logic [IR_W-1:0]     ir_in;
  logic [DR_W-1:0]     sr_in;
  logic                clr_status;
  logic [DR_W-1:0]     jdo;
  logic [NUM_CMDS-1:0] take_action;
  logic [NUM_CMDS-1:0] take_no_action;
  logic                busy;
  logic                overrun;
  logic [CNT_W-1:0]    cmd_count;

  modport master (
    output uir_in, udr_in, ir_in, sr_in, clr_status,
    input  jdo, take_action, take_no_action, busy, overrun, cmd_count
  );

  modport slave (
    input  uir_in, udr_in, ir_in, sr_in, clr_status,
    output jdo, take_action, take_no_action, busy, overrun, cmd_count
  );

endinterface

// File: rtl/jtag_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level plus a rising-edge detector.
// level_q is the synchronised level one cycle late, used for settled-low checks.
module jtag_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level_q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   level_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p  <= '0;
      level_p <= 1'b0;
    end else begin
      sync_p  <= {sync_p[SYNC_STAGES-2:0], d};
      level_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign level_q = level_p;
  assign rise    = sync_p[SYNC_STAGES-1] & ~level_p;

endmodule

// File: rtl/jtag_debug_cmd_sync.sv
// Sysclk-side JTAG debug command decoder: syncs update-IR/DR strobes, captures
// the scan register into jdo and issues one-cycle action / no-action pulses.
module jtag_debug_cmd_sync
  import jtag_debug_pkg::*;
#(
  parameter int IR_W        = DEF_IR_W,
  parameter int DR_W        = DEF_DR_W,
  parameter int ACT_BIT     = DEF_ACT_BIT,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  jtag_debug_cmd_sync_if.slave  bus
);

  localparam int NUM_CMDS = 2 ** IR_W;

  logic uir_rise, uir_level_unused;
  logic udr_rise, udr_level_q;

  jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset   (reset),
    .d       (bus.uir_in),
    .level_q (uir_level_unused),
    .rise    (uir_rise)
  );

  jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset   (reset),
    .d       (bus.udr_in),
    .level_q (udr_level_q),
    .rise    (udr_rise)
  );

  cmd_state_e          state_q, state_d;
  logic [DR_W-1:0]     jdo_q;
  logic [IR_W-1:0]     ir_q, cmd_ir_q;
  logic [NUM_CMDS-1:0] take_action_q, take_no_action_q;
  logic [NUM_CMDS-1:0] action_d, no_action_d;
  logic                overrun_q;
  logic [CNT_W-1:0]    cmd_count_q;
  logic                capture, issue, overrun_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // HOLD exits only once the synced udr has been low for a full cycle, so a
  // level still high, or a one-cycle dip, never re-arms the decoder.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (udr_rise) state_d = CAPTURE;
      CAPTURE: state_d = ISSUE;
      ISSUE:   state_d = HOLD;
      HOLD:    if (!udr_level_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulses are computed in CAPTURE and registered, so they are high while in ISSUE.
  always_comb begin
    capture     = (state_q == IDLE) && udr_rise;
    issue       = (state_q == CAPTURE);
    overrun_evt = (state_q != IDLE) && (udr_rise || uir_rise);
    action_d    = '0;
    no_action_d = '0;
    if (issue) begin
      if (jdo_q[ACT_BIT]) action_d[cmd_ir_q]    = 1'b1;
      else                no_action_d[cmd_ir_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo_q            <= '0;
      ir_q             <= '0;
      cmd_ir_q         <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      overrun_q        <= 1'b0;
      cmd_count_q      <= '0;
    end else begin
      if (uir_rise) ir_q <= bus.ir_in;
      if (capture) begin
        jdo_q    <= bus.sr_in;
        cmd_ir_q <= ir_q;
      end
      take_action_q    <= action_d;
      take_no_action_q <= no_action_d;
      if (overrun_evt)         overrun_q <= 1'b1;
      else if (bus.clr_status) overrun_q <= 1'b0;
      if (issue)               cmd_count_q <= (bus.clr_status ? '0 : cmd_count_q) + CNT_W'(1);
      else if (bus.clr_status) cmd_count_q <= '0;
    end
  end

  assign bus.jdo            = jdo_q;
  assign bus.take_action    = take_action_q;
  assign bus.take_no_action = take_no_action_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.overrun        = overrun_q;
  assign bus.cmd_count      = cmd_count_q;

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Directed bench for jtag_debug_cmd_sync: a CNT_W=16 instance is checked in
// detail, a CNT_W=4 twin shares its stimulus to show counter wrap.
module tb_jtag_debug_cmd_sync;
  import jtag_debug_pkg::*;

  localparam logic [37:0] SR1 = 38'h2A_1234_5678;
  localparam logic [37:0] SR2 = 38'h00_DEAD_BEEF;
  localparam logic [37:0] SR3 = 38'h08_0000_0001;

  logic        clk;
  logic        reset;
  logic        uir, udr, clr;
  logic [1:0]  ir;
  logic [37:0] sr;

  int n_cmp = 0;
  int n_mis = 0;
  int pulses = 0;
  int p0;
  logic [3:0] ta_or;

  jtag_debug_cmd_sync_if #(.CNT_W(16)) bus16 ();
  jtag_debug_cmd_sync_if #(.CNT_W(4))  bus4 ();

  assign bus16.uir_in = uir;  assign bus4.uir_in = uir;
  assign bus16.udr_in = udr;  assign bus4.udr_in = udr;
  assign bus16.ir_in  = ir;   assign bus4.ir_in  = ir;
  assign bus16.sr_in  = sr;   assign bus4.sr_in  = sr;
  assign bus16.clr_status = clr;
  assign bus4.clr_status  = clr;

  jtag_debug_cmd_sync #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  jtag_debug_cmd_sync #(.CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge, tallying pulses seen.
  task automatic tick();
    @(posedge clk);
    #1;
    pulses += $countones({bus16.take_action, bus16.take_no_action});
    ta_or  |= bus16.take_action;
  endtask

  task automatic send_ir(input logic [1:0] code);
    ir  = code;
    uir = 1'b1;
    repeat (4) tick();
    uir = 1'b0;
    repeat (4) tick();
  endtask

  task automatic issue_cmd();
    udr = 1'b1;
    repeat (4) tick();
    udr = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    reset = 1'b1; uir = 1'b0; udr = 1'b0; clr = 1'b0; ir = '0; sr = '0; ta_or = '0;
    tick(); tick();
    chk("rst_jdo",     64'(bus16.jdo), 64'h0);
    chk("rst_ta",      64'(bus16.take_action), 64'h0);
    chk("rst_tna",     64'(bus16.take_no_action), 64'h0);
    chk("rst_busy",    64'(bus16.busy), 64'h0);
    chk("rst_overrun", 64'(bus16.overrun), 64'h0);
    chk("rst_cnt",     64'(bus16.cmd_count), 64'h0);
    reset = 1'b0;
    tick(); tick();

    // Action command on BREAK: pulse high in the cycle after edge E0+3
    send_ir(BREAK);
    p0 = pulses; sr = SR1; udr = 1'b1;
    tick(); tick();
    chk("s1_busy_early", 64'(bus16.busy), 64'h0);
    tick();
    chk("s1_jdo",    64'(bus16.jdo), 64'(SR1));
    chk("s1_busy",   64'(bus16.busy), 64'h1);
    chk("s1_ta_pre", 64'(bus16.take_action), 64'h0);
    tick();
    chk("s1_ta",  64'(bus16.take_action), 64'h4);
    chk("s1_tna", 64'(bus16.take_no_action), 64'h0);
    chk("s1_cnt", 64'(bus16.cmd_count), 64'h1);
    tick();
    chk("s1_ta_end", 64'(bus16.take_action), 64'h0);
    udr = 1'b0;
    repeat (6) tick();
    chk("s1_idle",   64'(bus16.busy), 64'h0);
    chk("s1_pulses", 64'(pulses - p0), 64'h1);
    chk("s1_jdo_hold", 64'(bus16.jdo), 64'(SR1));

    // No-action command on OCIMEM
    send_ir(OCIMEM);
    p0 = pulses; sr = SR2; udr = 1'b1;
    repeat (4) tick();
    chk("s2_tna", 64'(bus16.take_no_action), 64'h1);
    chk("s2_ta",  64'(bus16.take_action), 64'h0);
    chk("s2_cnt", 64'(bus16.cmd_count), 64'h2);
    chk("s2_jdo", 64'(bus16.jdo), 64'(SR2));
    tick();
    chk("s2_tna_end", 64'(bus16.take_no_action), 64'h0);
    udr = 1'b0;
    repeat (6) tick();
    chk("s2_pulses", 64'(pulses - p0), 64'h1);

    // udr held high for 50 cycles: one pulse only; busy falls after L0+3
    send_ir(TRACEMEM);
    p0 = pulses; ta_or = '0; sr = SR3; udr = 1'b1;
    repeat (50) tick();
    chk("s3_pulses", 64'(pulses - p0), 64'h1);
    chk("s3_ta_or",  64'(ta_or), 64'h2);
    chk("s3_busy_hi", 64'(bus16.busy), 64'h1);
    udr = 1'b0;
    tick(); tick(); tick();
    chk("s3_busy_l2", 64'(bus16.busy), 64'h1);
    tick();
    chk("s3_busy_l3", 64'(bus16.busy), 64'h0);
    chk("s3_cnt", 64'(bus16.cmd_count), 64'h3);

    // One-cycle udr dip while in HOLD: overrun, dropped edge
    p0 = pulses; udr = 1'b1;
    repeat (6) tick();
    udr = 1'b0;
    tick();
    udr = 1'b1;
    repeat (8) tick();
    chk("s4_overrun", 64'(bus16.overrun), 64'h1);
    udr = 1'b0;
    repeat (6) tick();
    chk("s4_pulses", 64'(pulses - p0), 64'h1);
    chk("s4_cnt",    64'(bus16.cmd_count), 64'h4);
    chk("s4_sticky", 64'(bus16.overrun), 64'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s4_clr_ovr", 64'(bus16.overrun), 64'h0);
    chk("s4_clr_cnt", 64'(bus16.cmd_count), 64'h0);
    chk("s4_clr_cnt4", 64'(bus4.cmd_count), 64'h0);

    // 17 commands: 16-bit counter reads 17, 4-bit twin wraps to 1
    p0 = pulses;
    for (int i = 0; i < 17; i++) issue_cmd();
    chk("s5_cnt16",  64'(bus16.cmd_count), 64'd17);
    chk("s5_cnt4",   64'(bus4.cmd_count), 64'd1);
    chk("s5_pulses", 64'(pulses - p0), 64'd17);
    chk("s5_overrun", 64'(bus16.overrun), 64'h0);

    // Reset asserted while in CAPTURE
    p0 = pulses; sr = SR1; udr = 1'b1;
    tick(); tick(); tick();
    chk("s6_busy_pre", 64'(bus16.busy), 64'h1);
    chk("s6_jdo_pre",  64'(bus16.jdo), 64'(SR1));
    #1 reset = 1'b1;
    #1;
    chk("s6_jdo",  64'(bus16.jdo), 64'h0);
    chk("s6_busy", 64'(bus16.busy), 64'h0);
    chk("s6_cnt",  64'(bus16.cmd_count), 64'h0);
    chk("s6_ta",   64'(bus16.take_action), 64'h0);
    udr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("s6_no_pulse", 64'(pulses - p0), 64'h0);

    send_ir(BREAK);
    p0 = pulses; sr = SR1; udr = 1'b1;
    repeat (3) tick();
    chk("s7_jdo", 64'(bus16.jdo), 64'(SR1));
    tick();
    chk("s7_ta",  64'(bus16.take_action), 64'h4);
    chk("s7_cnt", 64'(bus16.cmd_count), 64'h1);
    udr = 1'b0;
    repeat (6) tick();
    chk("s7_pulses", 64'(pulses - p0), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
